// File: rtl/ddr_wr_pkg.sv
// Shared types and constants for the DDR write-burst to AXI4 bridge.
// Holds the FSM state encoding, AXI encodings, buffer depth and chunk helper.
package ddr_wr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_RESP,
      ST_FIN
   } wr_state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam int         AXI_MAX_BEATS  = 256;
   localparam int         WBUF_DEPTH     = 4;

   // Beats in the next AXI burst: min(rem, 256).
   function automatic logic [8:0] chunk_of(input logic [9:0] rem);
      if (rem > 10'(AXI_MAX_BEATS))
         return 9'(AXI_MAX_BEATS);
      return rem[8:0];
   endfunction

endpackage

// File: rtl/wr_data_skid_fifo.sv
// 4-entry register FIFO holding prefetched write beats ahead of the W channel.
// Ports: clk/rst, push+din (captured pull data), pop (W handshake), dout, not_empty, fill.
module wr_data_skid_fifo
   import ddr_wr_pkg::*;
#(
   parameter int DW = 512
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          not_empty,
   output logic [2:0]    fill
);

   localparam int PW = $clog2(WBUF_DEPTH);
   localparam int CW = PW + 1;

   logic [DW-1:0] mem [WBUF_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign not_empty = (cnt != '0);
   // Stale entries are hidden so the data port idles at zero.
   assign dout      = not_empty ? mem[rd_ptr] : '0;
   assign fill      = 3'(cnt);

endmodule

// File: rtl/ddr_wr_burst2axi.sv
// Converts the wr_burst_* request/data/finish handshake into AXI4 INCR write bursts.
// Ports: ddr_clk/ddr_rst, cfg_rst, wr_burst_* upstream, m_axi_aw/w/b master, burst/error counters.
module ddr_wr_burst2axi
   import ddr_wr_pkg::*;
#(
   parameter int DDR_ADDR_WD = 32,
   parameter int DDR_DATA_WD = 512
) (
   input  logic                     ddr_clk,
   input  logic                     ddr_rst,
   input  logic                     cfg_rst,
   input  logic                     wr_burst_req,
   input  logic [9:0]               wr_burst_len,
   input  logic [DDR_ADDR_WD-1:0]   wr_burst_addr,
   output logic                     wr_burst_data_req,
   input  logic [DDR_DATA_WD-1:0]   wr_burst_data,
   output logic                     wr_burst_finish,
   output logic [DDR_ADDR_WD-1:0]   m_axi_awaddr,
   output logic [7:0]               m_axi_awlen,
   output logic [2:0]               m_axi_awsize,
   output logic [1:0]               m_axi_awburst,
   output logic                     m_axi_awvalid,
   input  logic                     m_axi_awready,
   output logic [DDR_DATA_WD-1:0]   m_axi_wdata,
   output logic [DDR_DATA_WD/8-1:0] m_axi_wstrb,
   output logic                     m_axi_wlast,
   output logic                     m_axi_wvalid,
   input  logic                     m_axi_wready,
   input  logic [1:0]               m_axi_bresp,
   input  logic                     m_axi_bvalid,
   output logic                     m_axi_bready,
   output logic [31:0]              burst_cnt,
   output logic [31:0]              bresp_err_cnt
);

   localparam int AWSIZE = $clog2(DDR_DATA_WD / 8);

   wr_state_t              state;
   logic [DDR_ADDR_WD-1:0] addr;
   logic [9:0]             remaining;
   logic [9:0]             rem_next;
   logic [8:0]             chunk;
   logic [8:0]             load_chunk;
   logic [8:0]             requested;
   logic [8:0]             beat;
   logic                   pull_d;
   logic                   buf_valid;
   logic [2:0]             fill;
   logic                   pull_ok;
   logic                   start_chunk;
   logic                   aw_fire;
   logic                   w_fire;
   logic                   b_fire;

   assign rem_next   = remaining - {1'b0, chunk};
   assign load_chunk = (state == ST_IDLE) ? chunk_of(wr_burst_len)
                                          : chunk_of(rem_next);

   // Entry into ADDR from a fresh request or from a completed non-final chunk.
   assign start_chunk =
      (state == ST_IDLE && wr_burst_req && !wr_burst_finish &&
       wr_burst_len != '0) ||
      (b_fire && rem_next != '0);

   // Pulls in flight (current pulse + data arriving now) reserve buffer space.
   assign pull_ok = (requested < chunk) &&
      ((fill + {2'b0, wr_burst_data_req} + {2'b0, pull_d}) < 3'(WBUF_DEPTH));

   assign m_axi_awaddr  = addr;
   // Constant fields are only driven alongside valid so idle ports read zero.
   assign m_axi_awsize  = m_axi_awvalid ? 3'(AWSIZE) : 3'd0;
   assign m_axi_awburst = m_axi_awvalid ? AXI_BURST_INCR : 2'b00;
   assign m_axi_wvalid  = (state == ST_DATA) && buf_valid;
   assign m_axi_wstrb   = m_axi_wvalid ? '1 : '0;
   assign m_axi_wlast   = m_axi_wvalid && (beat == chunk - 9'd1);
   assign m_axi_bready  = (state == ST_RESP);

   assign aw_fire = m_axi_awvalid && m_axi_awready;
   assign w_fire  = m_axi_wvalid && m_axi_wready;
   assign b_fire  = m_axi_bvalid && m_axi_bready;

   wr_data_skid_fifo #(
      .DW(DDR_DATA_WD)
   ) u_wbuf (
      .clk      (ddr_clk),
      .rst      (ddr_rst),
      .push     (pull_d),
      .din      (wr_burst_data),
      .pop      (w_fire),
      .dout     (m_axi_wdata),
      .not_empty(buf_valid),
      .fill     (fill)
   );

   always_ff @(posedge ddr_clk or posedge ddr_rst) begin
      if (ddr_rst) begin
         state             <= ST_IDLE;
         addr              <= '0;
         remaining         <= '0;
         chunk             <= '0;
         requested         <= '0;
         beat              <= '0;
         pull_d            <= 1'b0;
         wr_burst_data_req <= 1'b0;
         wr_burst_finish   <= 1'b0;
         m_axi_awvalid     <= 1'b0;
         m_axi_awlen       <= '0;
      end else begin
         pull_d            <= wr_burst_data_req;
         wr_burst_data_req <= 1'b0;
         wr_burst_finish   <= 1'b0;
         if ((state == ST_ADDR || state == ST_DATA) && pull_ok) begin
            wr_burst_data_req <= 1'b1;
            requested         <= requested + 9'd1;
         end
         unique case (state)
            ST_IDLE: begin
               if (wr_burst_req && !wr_burst_finish) begin
                  addr      <= wr_burst_addr;
                  remaining <= wr_burst_len;
                  if (wr_burst_len == '0) state <= ST_FIN;
               end
            end
            ST_ADDR: begin
               if (aw_fire) begin
                  m_axi_awvalid <= 1'b0;
                  state         <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_fire) beat <= beat + 9'd1;
               if (w_fire && m_axi_wlast) state <= ST_RESP;
            end
            ST_RESP: begin
               if (b_fire) begin
                  remaining <= rem_next;
                  addr      <= addr + (DDR_ADDR_WD'(chunk) << AWSIZE);
                  if (rem_next == '0) state <= ST_FIN;
               end
            end
            ST_FIN: begin
               wr_burst_finish <= 1'b1;
               state           <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
         if (start_chunk) begin
            chunk             <= load_chunk;
            m_axi_awlen       <= 8'(load_chunk - 9'd1);
            m_axi_awvalid     <= 1'b1;
            wr_burst_data_req <= 1'b1;
            requested         <= 9'd1;
            beat              <= '0;
            state             <= ST_ADDR;
         end
      end
   end

   // Clear wins over a coincident B handshake.
   always_ff @(posedge ddr_clk or posedge ddr_rst) begin
      if (ddr_rst) begin
         burst_cnt     <= '0;
         bresp_err_cnt <= '0;
      end else if (cfg_rst) begin
         burst_cnt     <= '0;
         bresp_err_cnt <= '0;
      end else if (b_fire) begin
         burst_cnt <= burst_cnt + 32'd1;
         if (m_axi_bresp != AXI_RESP_OKAY)
            bresp_err_cnt <= bresp_err_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_ddr_wr_burst2axi.sv
// Directed bench for ddr_wr_burst2axi: table of whole requests plus reset sequences.
// A cycle-level responder models the data source and an AXI slave with scoreboarding.
module tb_ddr_wr_burst2axi;

   localparam int AW = 32;
   localparam int DW = 512;

   logic          ddr_clk = 1'b0;
   logic          ddr_rst;
   logic          cfg_rst;
   logic          wr_burst_req;
   logic [9:0]    wr_burst_len;
   logic [AW-1:0] wr_burst_addr;
   logic          wr_burst_data_req;
   logic [DW-1:0] wr_burst_data;
   logic          wr_burst_finish;
   logic [AW-1:0] m_axi_awaddr;
   logic [7:0]    m_axi_awlen;
   logic [2:0]    m_axi_awsize;
   logic [1:0]    m_axi_awburst;
   logic          m_axi_awvalid;
   logic          m_axi_awready;
   logic [DW-1:0] m_axi_wdata;
   logic [DW/8-1:0] m_axi_wstrb;
   logic          m_axi_wlast;
   logic          m_axi_wvalid;
   logic          m_axi_wready;
   logic [1:0]    m_axi_bresp;
   logic          m_axi_bvalid;
   logic          m_axi_bready;
   logic [31:0]   burst_cnt;
   logic [31:0]   bresp_err_cnt;

   always #5 ddr_clk = ~ddr_clk;

   ddr_wr_burst2axi #(
      .DDR_ADDR_WD(AW),
      .DDR_DATA_WD(DW)
   ) dut (
      .ddr_clk          (ddr_clk),
      .ddr_rst          (ddr_rst),
      .cfg_rst          (cfg_rst),
      .wr_burst_req     (wr_burst_req),
      .wr_burst_len     (wr_burst_len),
      .wr_burst_addr    (wr_burst_addr),
      .wr_burst_data_req(wr_burst_data_req),
      .wr_burst_data    (wr_burst_data),
      .wr_burst_finish  (wr_burst_finish),
      .m_axi_awaddr     (m_axi_awaddr),
      .m_axi_awlen      (m_axi_awlen),
      .m_axi_awsize     (m_axi_awsize),
      .m_axi_awburst    (m_axi_awburst),
      .m_axi_awvalid    (m_axi_awvalid),
      .m_axi_awready    (m_axi_awready),
      .m_axi_wdata      (m_axi_wdata),
      .m_axi_wstrb      (m_axi_wstrb),
      .m_axi_wlast      (m_axi_wlast),
      .m_axi_wvalid     (m_axi_wvalid),
      .m_axi_wready     (m_axi_wready),
      .m_axi_bresp      (m_axi_bresp),
      .m_axi_bvalid     (m_axi_bvalid),
      .m_axi_bready     (m_axi_bready),
      .burst_cnt        (burst_cnt),
      .bresp_err_cnt    (bresp_err_cnt)
   );

   typedef struct {
      int          len;
      logic [31:0] addr;
      bit          rand_w;
      int          aw_delay;
      logic [1:0]  bresp;
      int          exp_nb;
      int          exp_len0;
      int          exp_lenl;
      logic [31:0] exp_addrl;
      int          exp_err;
   } vec_t;

   vec_t vt[5];
   vec_t vpost;

   int checks = 0;
   int failures = 0;
   int exp_bursts = 0;
   int exp_errs = 0;

   // Configuration written by the main process only.
   int         tag = 0;
   bit         rand_w = 1'b0;
   int         aw_delay = 0;
   logic [1:0] bresp_val = 2'b00;
   int         clr_gen = 0;

   // Responder state and statistics, written by the responder only.
   int   cyc = 0;
   int   clr_seen = 0;
   bit   req_seen;
   int   cap_cnt, pulls, wcnt, wbeat, wb_idx, b_pend, aw_wait;
   int   derr, lerr, proto, ovf, udf, bubbles, fin_cnt;
   int   first_aw, first_pull;
   bit   in_burst;
   int   aw_len_q[$];
   logic [31:0] aw_addr_q[$];
   int   aw_cyc_q[$];
   int   b_cyc_q[$];

   function automatic logic [DW-1:0] pat(input int t, input int i);
      logic [31:0] w;
      w = (t << 16) | (i & 32'h0000FFFF);
      return {16{w}};
   endfunction

   function automatic logic [15:0] out_sig();
      return {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
              wr_burst_data_req, wr_burst_finish, |m_axi_awaddr,
              |m_axi_awlen, |m_axi_awsize, |m_axi_awburst, |m_axi_wdata,
              |m_axi_wstrb, |burst_cnt, |bresp_err_cnt, 2'b00};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Data source and AXI slave, evaluated 1 time unit after each edge.
   always @(posedge ddr_clk) begin
      int occ;
      #1;
      cyc++;
      if (clr_gen != clr_seen) begin
         clr_seen = clr_gen;
         cap_cnt = 0; pulls = 0; wcnt = 0; wbeat = 0; wb_idx = 0;
         derr = 0; lerr = 0; proto = 0; ovf = 0; udf = 0;
         bubbles = 0; fin_cnt = 0; first_aw = -1; first_pull = -1;
         in_burst = 0;
         aw_len_q.delete(); aw_addr_q.delete();
         aw_cyc_q.delete(); b_cyc_q.delete();
      end
      if (ddr_rst) begin
         req_seen = 0; b_pend = 0; aw_wait = 0; in_burst = 0; wbeat = 0;
         m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
         m_axi_bresp = 2'b00; wr_burst_data = '0;
      end else begin
         occ = cap_cnt - wcnt;
         if (occ > 4) ovf++;
         if (req_seen) begin
            wr_burst_data = pat(tag, cap_cnt);
            cap_cnt++;
         end
         req_seen = wr_burst_data_req;
         if (wr_burst_data_req) begin
            pulls++;
            if (first_pull < 0) first_pull = cyc;
         end
         m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
         m_axi_wready  = rand_w ? 1'($urandom % 2) : 1'b1;
         m_axi_bvalid  = (b_pend > 0);
         m_axi_bresp   = bresp_val;
         if (m_axi_awvalid) begin
            if (first_aw < 0) first_aw = cyc;
            if (m_axi_awready) begin
               aw_len_q.push_back(int'(m_axi_awlen));
               aw_addr_q.push_back(m_axi_awaddr);
               aw_cyc_q.push_back(cyc);
               if (m_axi_awsize != 3'd6 || m_axi_awburst != 2'b01) proto++;
               aw_wait = 0;
            end else begin
               aw_wait++;
            end
         end
         if (m_axi_wvalid) begin
            if (m_axi_wstrb != '1) proto++;
            if (occ < 1) udf++;
            if (m_axi_wready) begin
               if (m_axi_wdata != pat(tag, wcnt)) derr++;
               if (wb_idx >= aw_len_q.size()) proto++;
               else if (m_axi_wlast != (wbeat == aw_len_q[wb_idx])) lerr++;
               wcnt++;
               in_burst = 1;
               if (m_axi_wlast) begin
                  wb_idx++; wbeat = 0; in_burst = 0; b_pend++;
               end else begin
                  wbeat++;
               end
            end
         end else if (in_burst) begin
            bubbles++;
         end
         if (m_axi_bvalid && m_axi_bready) begin
            b_pend--;
            b_cyc_q.push_back(cyc);
         end
         if (wr_burst_finish) fin_cnt++;
      end
   end

   task automatic run_vec(input vec_t v, input int t);
      int got, fin_c, req_c, n;
      tag = t; rand_w = v.rand_w; aw_delay = v.aw_delay; bresp_val = v.bresp;
      clr_gen++;
      @(negedge ddr_clk);
      wr_burst_req  = 1'b1;
      wr_burst_len  = 10'(v.len);
      wr_burst_addr = v.addr;
      req_c = cyc;
      got = 0; fin_c = 0;
      for (int k = 0; k < 3000 && got == 0; k++) begin
         @(negedge ddr_clk);
         if (wr_burst_finish) begin got = 1; fin_c = cyc; end
      end
      wr_burst_req = 1'b0;
      chk($sformatf("v%0d_finish_seen", t), got, 1);
      repeat (3) @(negedge ddr_clk);
      exp_bursts += v.exp_nb;
      exp_errs   += v.exp_err;
      n = aw_len_q.size();
      chk($sformatf("v%0d_aw_count", t), n, v.exp_nb);
      chk($sformatf("v%0d_pulls", t), pulls, v.len);
      chk($sformatf("v%0d_w_beats", t), wcnt, v.len);
      chk($sformatf("v%0d_data_err", t), derr, 0);
      chk($sformatf("v%0d_wlast_err", t), lerr, 0);
      chk($sformatf("v%0d_proto_err", t), proto, 0);
      chk($sformatf("v%0d_buf_ovf", t), ovf, 0);
      chk($sformatf("v%0d_buf_udf", t), udf, 0);
      chk($sformatf("v%0d_finish_pulses", t), fin_cnt, 1);
      chk($sformatf("v%0d_burst_cnt", t), burst_cnt, exp_bursts);
      chk($sformatf("v%0d_err_cnt", t), bresp_err_cnt, exp_errs);
      if (v.exp_nb > 0 && n > 0) begin
         chk($sformatf("v%0d_awaddr0", t), aw_addr_q[0], v.addr);
         chk($sformatf("v%0d_awlen0", t), aw_len_q[0], v.exp_len0);
         chk($sformatf("v%0d_awlen_last", t), aw_len_q[n-1], v.exp_lenl);
         chk($sformatf("v%0d_awaddr_last", t), aw_addr_q[n-1], v.exp_addrl);
         chk($sformatf("v%0d_awvalid_lat", t), first_aw - req_c, 1);
         chk($sformatf("v%0d_pull_lat", t), first_pull - req_c, 1);
         if (b_cyc_q.size() > 0)
            chk($sformatf("v%0d_fin_after_b", t),
                fin_c - b_cyc_q[b_cyc_q.size()-1], 2);
         if (!v.rand_w)
            chk($sformatf("v%0d_w_bubbles", t), bubbles, 0);
         if (n > 1 && b_cyc_q.size() > 0)
            chk($sformatf("v%0d_next_aw_lat", t), aw_cyc_q[1] - b_cyc_q[0], 1);
      end else begin
         chk($sformatf("v%0d_len0_latency", t), (fin_c - req_c) <= 3, 1);
         chk($sformatf("v%0d_len0_no_aw", t), first_aw, -1);
      end
   endtask

   initial begin
      int hit;
      ddr_rst = 1'b1; cfg_rst = 1'b0; wr_burst_req = 1'b0;
      wr_burst_len = '0; wr_burst_addr = '0;
      repeat (3) @(negedge ddr_clk);
      chk("reset_outputs", out_sig(), 0);
      ddr_rst = 1'b0;
      @(negedge ddr_clk);
      chk("idle_outputs", out_sig(), 0);

      //         len  addr        rnd dly bresp nb len0 lenl addrl       err
      vt[0] = '{16,  32'h1000, 0, 0, 2'b00, 1, 15,  15, 32'h1000, 0};
      vt[1] = '{300, 32'h0000, 0, 0, 2'b00, 2, 255, 43, 32'h4000, 0};
      vt[2] = '{0,   32'h2000, 0, 0, 2'b00, 0, 0,   0,  32'h0,    0};
      vt[3] = '{64,  32'h8000, 1, 5, 2'b00, 1, 63,  63, 32'h8000, 0};
      vt[4] = '{8,   32'h0100, 0, 0, 2'b10, 1, 7,   7,  32'h0100, 1};
      for (int i = 0; i < 5; i++) run_vec(vt[i], i + 1);

      // Counter clear after the error response.
      @(negedge ddr_clk);
      cfg_rst = 1'b1;
      @(negedge ddr_clk);
      cfg_rst = 1'b0;
      chk("cfg_rst_burst_cnt", burst_cnt, 0);
      chk("cfg_rst_err_cnt", bresp_err_cnt, 0);
      exp_bursts = 0; exp_errs = 0;

      // Asynchronous reset in the middle of a W burst.
      tag = 7; rand_w = 0; aw_delay = 0; bresp_val = 2'b00;
      clr_gen++;
      @(negedge ddr_clk);
      wr_burst_req = 1'b1; wr_burst_len = 10'd32; wr_burst_addr = 32'h3000;
      hit = 0;
      for (int k = 0; k < 200 && hit == 0; k++) begin
         @(negedge ddr_clk);
         if (wcnt >= 5) hit = 1;
      end
      chk("rst_reached_data", hit, 1);
      ddr_rst = 1'b1;
      wr_burst_req = 1'b0;
      #1;
      chk("rst_async_outputs", out_sig(), 0);
      chk("rst_async_wvalid", m_axi_wvalid, 0);
      repeat (2) @(negedge ddr_clk);
      ddr_rst = 1'b0;
      @(negedge ddr_clk);
      vpost = '{4, 32'h0500, 0, 0, 2'b00, 1, 3, 3, 32'h0500, 0};
      run_vec(vpost, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
